imem_dmem_arbiter: RTL and testbench

- Shares one single-port synchronous memory between two requesters: the MIPSCPU instruction-fetch port and the load/store (MEM-stage) port.
- Grants the memory each cycle, routes read data back to the owner one cycle later, and drives stall requests into the pipeline.
- Bounds instruction-fetch starvation with a fairness counter.
- Sits between MIPSCPU and the unified memory model that replaces separate instruction ROM and data RAM in the unified-memory build.

---
 rtl/imem_dmem_arbiter.sv | 121 ++++++++++++
 tb/tb_imem_dmem_arbiter.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_dmem_arbiter.sv
// imem_dmem_arbiter: shares one single-port synchronous memory between the
// instruction-fetch port and the load/store port of the CPU.
//   if_*    : fetch requester (read-only). Ack is same-cycle; data is one cycle later.
//   d_*     : load/store requester. Ack is same-cycle; load data is one cycle later.
//   mem_*   : single-port memory. Read data is valid the cycle after a read enable.
//   stall_* : pipeline stall requests (request pending but not granted).
// Data normally wins a conflict. A starvation counter forces fetch to win
// after MAX_IF_WAIT consecutive data grants taken while fetch was waiting.
module imem_dmem_arbiter #(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned MAX_IF_WAIT = 4
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                if_req_i,
    input  logic [ADDR_W-1:0]   if_addr_i,
    output logic                if_ack_o,
    output logic                if_rvalid_o,
    output logic [DATA_W-1:0]   if_rdata_o,

    input  logic                d_req_i,
    input  logic                d_we_i,
    input  logic [ADDR_W-1:0]   d_addr_i,
    input  logic [DATA_W-1:0]   d_wdata_i,
    input  logic [DATA_W/8-1:0] d_sel_i,
    output logic                d_ack_o,
    output logic                d_rvalid_o,
    output logic [DATA_W-1:0]   d_rdata_o,

    output logic                mem_ce_o,
    output logic                mem_we_o,
    output logic [ADDR_W-1:0]   mem_addr_o,
    output logic [DATA_W-1:0]   mem_wdata_o,
    output logic [DATA_W/8-1:0] mem_sel_o,
    input  logic [DATA_W-1:0]   mem_rdata_i,

    output logic                stall_if_o,
    output logic                stall_mem_o
);

    localparam int unsigned SEL_W = DATA_W / 8;
    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_IF_WAIT);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_D    = 2'd2
    } owner_e;

    owner_e           rd_owner_q, rd_owner_d;
    logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;

    logic fetch_win, data_win;

    // State registers: read-return owner and fetch starvation counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_owner_q   <= OWN_NONE;
            starve_cnt_q <= '0;
        end else begin
            rd_owner_q   <= rd_owner_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

    // Grant, memory mux, read-owner and starvation next-state.
    always_comb begin
        fetch_win    = 1'b0;
        data_win     = 1'b0;
        if_ack_o     = 1'b0;
        d_ack_o      = 1'b0;
        mem_ce_o     = 1'b0;
        mem_we_o     = 1'b0;
        mem_addr_o   = '0;
        mem_wdata_o  = '0;
        mem_sel_o    = '0;
        rd_owner_d   = OWN_NONE;
        starve_cnt_d = starve_cnt_q;

        // Fetch only wins a conflict once it has waited out its budget.
        fetch_win = if_req_i & (~d_req_i | (starve_cnt_q == CNT_MAX));
        data_win  = d_req_i & ~fetch_win;

        if (!rst) begin
            if (fetch_win) begin
                if_ack_o   = 1'b1;
                mem_ce_o   = 1'b1;
                mem_addr_o = if_addr_i;
                mem_sel_o  = {SEL_W{1'b1}};
                rd_owner_d = OWN_IF;
            end else if (data_win) begin
                d_ack_o     = 1'b1;
                mem_ce_o    = 1'b1;
                mem_we_o    = d_we_i;
                mem_addr_o  = d_addr_i;
                mem_wdata_o = d_wdata_i;
                mem_sel_o   = d_sel_i;
                rd_owner_d  = d_we_i ? OWN_NONE : OWN_D;
            end
        end

        if (if_ack_o || !if_req_i) begin
            starve_cnt_d = '0;
        end else if (d_ack_o && (starve_cnt_q != CNT_MAX)) begin
            starve_cnt_d = starve_cnt_q + CNT_W'(1);
        end
    end

    // Read return; reset suppresses everything, including a pending return.
    assign if_rvalid_o = ~rst & (rd_owner_q == OWN_IF);
    assign d_rvalid_o  = ~rst & (rd_owner_q == OWN_D);
    assign if_rdata_o  = if_rvalid_o ? mem_rdata_i : '0;
    assign d_rdata_o   = d_rvalid_o  ? mem_rdata_i : '0;

    assign stall_if_o  = ~rst & if_req_i & ~if_ack_o;
    assign stall_mem_o = ~rst & d_req_i  & ~d_ack_o;

endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// Bench for imem_dmem_arbiter: directed vector table, a reset-mid-read
// sequence, idle cycles, then random traffic against a transaction-level model.
module tb_imem_dmem_arbiter;

    localparam int unsigned MAXW = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_ack, if_rvalid;
    logic [31:0] if_rdata;
    logic        d_req, d_we;
    logic [31:0] d_addr, d_wdata;
    logic [3:0]  d_sel;
    logic        d_ack, d_rvalid;
    logic [31:0] d_rdata;
    logic        mem_ce, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_sel;
    logic [31:0] mem_rdata;
    logic        stall_if, stall_mem;

    int checks = 0;
    int errors = 0;

    imem_dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_IF_WAIT(MAXW)) dut (
        .clk(clk), .rst(rst),
        .if_req_i(if_req), .if_addr_i(if_addr), .if_ack_o(if_ack),
        .if_rvalid_o(if_rvalid), .if_rdata_o(if_rdata),
        .d_req_i(d_req), .d_we_i(d_we), .d_addr_i(d_addr), .d_wdata_i(d_wdata),
        .d_sel_i(d_sel), .d_ack_o(d_ack), .d_rvalid_o(d_rvalid), .d_rdata_o(d_rdata),
        .mem_ce_o(mem_ce), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
        .mem_wdata_o(mem_wdata), .mem_sel_o(mem_sel), .mem_rdata_i(mem_rdata),
        .stall_if_o(stall_if), .stall_mem_o(stall_mem)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return 32'h3401_0001 + {a[31:2], 2'b00};
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] sel);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (sel[b]) r[b*8 +: 8] = nw[b*8 +: 8];
        return r;
    endfunction

    // Memory environment driven by the DUT memory port.
    logic [31:0] env_mem [int unsigned];
    always @(posedge clk) begin
        if (mem_ce) begin
            if (mem_we) begin
                env_mem[mem_addr[31:2]] = merge(env_mem.exists(mem_addr[31:2]) ?
                    env_mem[mem_addr[31:2]] : init_word(mem_addr), mem_wdata, mem_sel);
            end else begin
                mem_rdata <= env_mem.exists(mem_addr[31:2]) ? env_mem[mem_addr[31:2]]
                                                            : init_word(mem_addr);
            end
        end
    end

    // Reference model: who owns the next read return, how long fetch has waited.
    logic [31:0] shadow [int unsigned];
    int          m_wait;       // data grants taken while fetch waited
    int          m_ret;        // 0 none, 1 fetch return pending, 2 load return pending
    logic [31:0] m_ret_word;
    logic        m_fw, m_dw;

    function automatic logic [31:0] shadow_rd(input logic [31:0] a);
        return shadow.exists(a[31:2]) ? shadow[a[31:2]] : init_word(a);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic decide();
        m_fw = !rst && if_req && (!d_req || m_wait >= MAXW);
        m_dw = !rst && d_req && !m_fw;
    endtask

    task automatic model_check();
        logic [31:0] e_addr, e_wd;
        logic [3:0]  e_sel;
        decide();
        e_addr = m_fw ? if_addr : (m_dw ? d_addr : 32'h0);
        e_wd   = m_dw ? d_wdata : 32'h0;
        e_sel  = m_fw ? 4'hF : (m_dw ? d_sel : 4'h0);
        chk("if_ack", 32'(if_ack), 32'(m_fw));
        chk("d_ack", 32'(d_ack), 32'(m_dw));
        chk("mem_ce", 32'(mem_ce), 32'(m_fw || m_dw));
        chk("mem_we", 32'(mem_we), 32'(m_dw && d_we));
        chk("mem_addr", mem_addr, e_addr);
        chk("mem_wdata", mem_wdata, e_wd);
        chk("mem_sel", 32'(mem_sel), 32'(e_sel));
        chk("if_rvalid", 32'(if_rvalid), 32'(!rst && m_ret == 1));
        chk("d_rvalid", 32'(d_rvalid), 32'(!rst && m_ret == 2));
        chk("if_rdata", if_rdata, (!rst && m_ret == 1) ? m_ret_word : 32'h0);
        chk("d_rdata", d_rdata, (!rst && m_ret == 2) ? m_ret_word : 32'h0);
        chk("stall_if", 32'(stall_if), 32'(!rst && if_req && !m_fw));
        chk("stall_mem", 32'(stall_mem), 32'(!rst && d_req && !m_dw));
    endtask

    task automatic model_update();
        decide();
        if (rst) begin
            m_wait = 0;
            m_ret  = 0;
        end else begin
            m_ret = 0;
            if (m_fw) begin
                m_ret = 1;
                m_ret_word = shadow_rd(if_addr);
            end else if (m_dw && !d_we) begin
                m_ret = 2;
                m_ret_word = shadow_rd(d_addr);
            end else if (m_dw) begin
                shadow[d_addr[31:2]] = merge(shadow_rd(d_addr), d_wdata, d_sel);
            end
            if (m_fw || !if_req) m_wait = 0;
            else if (m_dw && m_wait < MAXW) m_wait++;
        end
    endtask

    task automatic step();
        @(negedge clk);
        model_check();
        @(posedge clk);
        model_update();
        #1;
    endtask

    typedef struct {
        logic        rst, ir;
        logic [31:0] ia;
        logic        dr, dwe;
        logic [31:0] da, dwd;
        logic [3:0]  dsel;
        logic        eia, eda, eirv, edrv;
        logic [31:0] erd;
        logic        ewe, esi, esm;
    } vec_t;
    vec_t vec_q [$];

    function automatic vec_t mk(
        input logic r, input logic ir, input logic [31:0] ia, input logic dr,
        input logic dwe, input logic [31:0] da, input logic [31:0] dwd,
        input logic [3:0] dsel, input logic eia, input logic eda, input logic eirv,
        input logic edrv, input logic [31:0] erd, input logic ewe, input logic esi,
        input logic esm);
        vec_t v;
        v.rst = r; v.ir = ir; v.ia = ia; v.dr = dr; v.dwe = dwe; v.da = da;
        v.dwd = dwd; v.dsel = dsel; v.eia = eia; v.eda = eda; v.eirv = eirv;
        v.edrv = edrv; v.erd = erd; v.ewe = ewe; v.esi = esi; v.esm = esm;
        return v;
    endfunction

    logic if_pend, d_pend;

    initial begin
        rst = 1'b1; if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0;
        d_addr = '0; d_wdata = '0; d_sel = '0; mem_rdata = '0;
        m_wait = 0; m_ret = 0; m_ret_word = '0;

        // rst ir ia dr we da wd sel | eia eda eirv edrv erd ewe esi esm
        vec_q.push_back(mk(1,1,32'h0,  0,0,32'h0,  32'h0,4'h0, 0,0,0,0,32'h0,0,0,0));
        vec_q.push_back(mk(1,0,32'h0,  0,0,32'h0,  32'h0,4'h0, 0,0,0,0,32'h0,0,0,0));
        vec_q.push_back(mk(0,1,32'h0,  0,0,32'h0,  32'h0,4'h0, 1,0,0,0,32'h0,0,0,0));
        vec_q.push_back(mk(0,1,32'h4,  0,0,32'h0,  32'h0,4'h0, 1,0,1,0,32'h34010001,0,0,0));
        vec_q.push_back(mk(0,1,32'h8,  0,0,32'h0,  32'h0,4'h0, 1,0,1,0,32'h34010005,0,0,0));
        vec_q.push_back(mk(0,0,32'h0,  0,0,32'h0,  32'h0,4'h0, 0,0,1,0,32'h34010009,0,0,0));
        vec_q.push_back(mk(0,1,32'hC,  1,0,32'h100,32'h0,4'h0, 0,1,0,0,32'h0,0,1,0));
        vec_q.push_back(mk(0,1,32'hC,  0,0,32'h0,  32'h0,4'h0, 1,0,0,1,32'h34010101,0,0,0));
        vec_q.push_back(mk(0,0,32'h0,  0,0,32'h0,  32'h0,4'h0, 0,0,1,0,32'h3401000D,0,0,0));
        vec_q.push_back(mk(0,0,32'h0,  1,1,32'h200,32'hDEADBEEF,4'h3, 0,1,0,0,32'h0,1,0,0));
        vec_q.push_back(mk(0,0,32'h0,  0,0,32'h0,  32'h0,4'h0, 0,0,0,0,32'h0,0,0,0));
        vec_q.push_back(mk(0,0,32'h0,  1,0,32'h200,32'h0,4'h0, 0,1,0,0,32'h0,0,0,0));
        vec_q.push_back(mk(0,0,32'h0,  0,0,32'h0,  32'h0,4'h0, 0,0,0,1,32'h3401BEEF,0,0,0));
        vec_q.push_back(mk(0,0,32'h0,  1,0,32'h104,32'h0,4'h0, 0,1,0,0,32'h0,0,0,0));
        vec_q.push_back(mk(0,0,32'h0,  1,1,32'h108,32'h1,4'hF, 0,1,0,1,32'h34010105,1,0,0));
        vec_q.push_back(mk(0,0,32'h0,  0,0,32'h0,  32'h0,4'h0, 0,0,0,0,32'h0,0,0,0));
        vec_q.push_back(mk(0,1,32'h10, 1,0,32'h20, 32'h0,4'h0, 0,1,0,0,32'h0,0,1,0));
        vec_q.push_back(mk(0,1,32'h10, 1,0,32'h24, 32'h0,4'h0, 0,1,0,1,32'h34010021,0,1,0));
        vec_q.push_back(mk(0,1,32'h10, 1,0,32'h28, 32'h0,4'h0, 0,1,0,1,32'h34010025,0,1,0));
        vec_q.push_back(mk(0,1,32'h10, 1,0,32'h2C, 32'h0,4'h0, 0,1,0,1,32'h34010029,0,1,0));
        vec_q.push_back(mk(0,1,32'h10, 1,0,32'h30, 32'h0,4'h0, 1,0,0,1,32'h3401002D,0,0,1));
        vec_q.push_back(mk(0,1,32'h14, 1,0,32'h30, 32'h0,4'h0, 0,1,1,0,32'h34010011,0,1,0));
        vec_q.push_back(mk(0,0,32'h0,  1,0,32'h34, 32'h0,4'h0, 0,1,0,1,32'h34010031,0,0,0));
        vec_q.push_back(mk(0,0,32'h0,  0,0,32'h0,  32'h0,4'h0, 0,0,0,1,32'h34010035,0,0,0));

        #1;
        foreach (vec_q[i]) begin
            rst = vec_q[i].rst; if_req = vec_q[i].ir; if_addr = vec_q[i].ia;
            d_req = vec_q[i].dr; d_we = vec_q[i].dwe; d_addr = vec_q[i].da;
            d_wdata = vec_q[i].dwd; d_sel = vec_q[i].dsel;
            @(negedge clk);
            model_check();
            chk($sformatf("v%0d_if_ack", i), 32'(if_ack), 32'(vec_q[i].eia));
            chk($sformatf("v%0d_d_ack", i), 32'(d_ack), 32'(vec_q[i].eda));
            chk($sformatf("v%0d_if_rvalid", i), 32'(if_rvalid), 32'(vec_q[i].eirv));
            chk($sformatf("v%0d_d_rvalid", i), 32'(d_rvalid), 32'(vec_q[i].edrv));
            chk($sformatf("v%0d_rdata", i), if_rdata | d_rdata, vec_q[i].erd);
            chk($sformatf("v%0d_mem_we", i), 32'(mem_we), 32'(vec_q[i].ewe));
            chk($sformatf("v%0d_stall_if", i), 32'(stall_if), 32'(vec_q[i].esi));
            chk($sformatf("v%0d_stall_mem", i), 32'(stall_mem), 32'(vec_q[i].esm));
            @(posedge clk);
            model_update();
            #1;
        end

        // Reset arriving late in a fetch-grant cycle squashes the return.
        rst = 1'b0; if_req = 1'b1; if_addr = 32'h40; d_req = 1'b0;
        @(negedge clk);
        model_check();
        chk("rstmid_ack_before", 32'(if_ack), 32'h1);
        rst = 1'b1;
        #1;
        model_check();
        chk("rstmid_ack_forced", 32'(if_ack), 32'h0);
        chk("rstmid_ce_forced", 32'(mem_ce), 32'h0);
        @(posedge clk);
        model_update();
        #1;
        @(negedge clk);
        model_check();
        chk("rstmid_rvalid", 32'(if_rvalid), 32'h0);
        chk("rstmid_stall", 32'(stall_if), 32'h0);
        @(posedge clk);
        model_update();
        #1;
        rst = 1'b0; if_addr = 32'h44;
        @(negedge clk);
        model_check();
        chk("rstmid_resume_ack", 32'(if_ack), 32'h1);
        @(posedge clk);
        model_update();
        #1;
        if_req = 1'b0;
        @(negedge clk);
        model_check();
        chk("rstmid_resume_data", if_rdata, 32'h34010045);
        @(posedge clk);
        model_update();
        #1;

        // Idle stretch.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            model_check();
            chk("idle_ce", 32'(mem_ce), 32'h0);
            chk("idle_stalls", 32'({stall_if, stall_mem}), 32'h0);
            @(posedge clk);
            model_update();
            #1;
        end

        // Random traffic; requests are held until the model predicts an ack.
        if_pend = 1'b0; d_pend = 1'b0;
        for (int c = 0; c < 1500; c++) begin
            rst = ($urandom_range(0, 99) == 0);
            if (!if_pend) begin
                if_req  = ($urandom_range(0, 3) != 0);
                if_addr = {24'h0, 6'($urandom), 2'b00};
            end
            if (!d_pend) begin
                d_req   = ($urandom_range(0, 2) != 0);
                d_we    = $urandom_range(0, 1) == 1;
                d_addr  = {24'h0, 6'($urandom), 2'b00};
                d_wdata = $urandom;
                d_sel   = 4'($urandom);
            end
            @(negedge clk);
            model_check();
            @(posedge clk);
            model_update();
            if_pend = if_req && !m_fw;
            d_pend  = d_req && !m_dw;
            #1;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout act=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
